// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter and fixed-latency access sequencer for a shared data memory port.
// Every transaction runs IDLE -> ACCESS -> RESP, so one access completes every 3 cycles.
module data_memory_arbiter #(
  parameter int unsigned AddrWidth = 24,
  parameter int unsigned DataWidth = 24,
  parameter int unsigned MemBytes  = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_i,
  input  logic                 req1_i,
  input  logic                 write0_i,
  input  logic                 write1_i,
  input  logic [AddrWidth-1:0] address0_i,
  input  logic [AddrWidth-1:0] address1_i,
  input  logic [DataWidth-1:0] write_data0_i,
  input  logic [DataWidth-1:0] write_data1_i,
  output logic                 gnt0_o,
  output logic                 gnt1_o,
  output logic                 done0_o,
  output logic                 done1_o,
  output logic                 error0_o,
  output logic                 error1_o,
  output logic [DataWidth-1:0] read_data0_o,
  output logic [DataWidth-1:0] read_data1_o,
  output logic [AddrWidth-1:0] mem_address_o,
  output logic [DataWidth-1:0] mem_write_data_o,
  output logic                 mem_write_o,
  output logic                 mem_read_o,
  input  logic [DataWidth-1:0] mem_read_data_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  // Highest address whose 3-byte word still fits in the memory.
  localparam logic [AddrWidth-1:0] LastLegal = AddrWidth'(MemBytes - 3);

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_gnt_q, last_gnt_d;
  logic                 write_q, write_d;
  logic                 range_err_q, range_err_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [DataWidth-1:0] rdata0_q, rdata0_d;
  logic [DataWidth-1:0] rdata1_q, rdata1_d;
  logic                 pick;
  logic [AddrWidth-1:0] sel_addr;
  logic [DataWidth-1:0] load_val;

  // State and operand registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      last_gnt_q  <= 1'b1;
      write_q     <= 1'b0;
      range_err_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_gnt_q  <= last_gnt_d;
      write_q     <= write_d;
      range_err_q <= range_err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  // Next-state: arbitrate and latch in IDLE, capture load data at the end of ACCESS.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_gnt_d  = last_gnt_q;
    write_d     = write_q;
    range_err_d = range_err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    pick        = 1'b0;
    sel_addr    = address0_i;
    load_val    = '0;
    unique case (state_q)
      StIdle: begin
        if (req0_i || req1_i) begin
          // On a tie the requester not granted last wins.
          pick        = (req0_i && req1_i) ? ~last_gnt_q : req1_i;
          sel_addr    = pick ? address1_i : address0_i;
          owner_d     = pick;
          last_gnt_d  = pick;
          write_d     = pick ? write1_i : write0_i;
          addr_d      = sel_addr;
          wdata_d     = pick ? write_data1_i : write_data0_i;
          range_err_d = (sel_addr > LastLegal);
          state_d     = StAccess;
        end
      end
      StAccess: begin
        // Stores and rejected accesses leave the owner's read data at zero.
        load_val = (write_q || range_err_q) ? '0 : mem_read_data_i;
        if (owner_q) rdata1_d = load_val;
        else         rdata0_d = load_val;
        state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from state; memory strobes fall as soon as reset clears the state.
  always_comb begin
    gnt0_o           = (state_q != StIdle) && !owner_q;
    gnt1_o           = (state_q != StIdle) && owner_q;
    done0_o          = (state_q == StResp) && !owner_q;
    done1_o          = (state_q == StResp) && owner_q;
    error0_o         = done0_o && range_err_q;
    error1_o         = done1_o && range_err_q;
    mem_write_o      = (state_q == StAccess) && write_q && !range_err_q;
    mem_read_o       = (state_q == StAccess) && !write_q && !range_err_q;
    mem_address_o    = addr_q;
    mem_write_data_o = wdata_q;
    read_data0_o     = rdata0_q;
    read_data1_o     = rdata1_q;
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a 128-byte big-endian memory model.
module tb_data_memory_arbiter;

  logic        clk, rst;
  logic        req0, req1, write0, write1;
  logic [23:0] address0, address1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, error0, error1;
  logic [23:0] rd0, rd1, mem_address, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;
  logic        mem_init;
  logic [7:0]  mem [128];

  int total = 0;
  int bad   = 0;

  data_memory_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .req0_i           (req0),
    .req1_i           (req1),
    .write0_i         (write0),
    .write1_i         (write1),
    .address0_i       (address0),
    .address1_i       (address1),
    .write_data0_i    (wdata0),
    .write_data1_i    (wdata1),
    .gnt0_o           (gnt0),
    .gnt1_o           (gnt1),
    .done0_o          (done0),
    .done1_o          (done1),
    .error0_o         (error0),
    .error1_o         (error1),
    .read_data0_o     (rd0),
    .read_data1_o     (rd1),
    .mem_address_o    (mem_address),
    .mem_write_data_o (mem_wdata),
    .mem_write_o      (mem_write),
    .mem_read_o       (mem_read),
    .mem_read_data_i  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: image load while mem_init, otherwise rising-edge write.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i);
      mem[9]   <= 8'h12; mem[10]  <= 8'h34; mem[11]  <= 8'h56;
      mem[40]  <= 8'h01; mem[41]  <= 8'h02; mem[42]  <= 8'h03;
      mem[125] <= 8'h77; mem[126] <= 8'h88; mem[127] <= 8'h99;
    end else if (mem_write && mem_address <= 24'd125) begin
      mem[mem_address[6:0]]        <= mem_wdata[23:16];
      mem[mem_address[6:0] + 7'd1] <= mem_wdata[15:8];
      mem[mem_address[6:0] + 7'd2] <= mem_wdata[7:0];
    end
  end

  // Combinational big-endian read.
  always_comb begin
    mem_rdata = '0;
    if (mem_address <= 24'd125)
      mem_rdata = {mem[mem_address[6:0]], mem[mem_address[6:0] + 7'd1],
                   mem[mem_address[6:0] + 7'd2]};
  end

  typedef struct {
    logic        own;
    logic        w;
    logic [23:0] addr;
    logic [23:0] wdata;
    logic        err;
    int          rdp;
    int          wrp;
    logic [23:0] exp_rd0;
    logic [23:0] exp_rd1;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(logic own, logic w, logic [23:0] addr, logic [23:0] wdata,
                              logic err, int rdp, int wrp, logic [23:0] e0, logic [23:0] e1);
    vec_t v;
    v.own = own; v.w = w; v.addr = addr; v.wdata = wdata; v.err = err;
    v.rdp = rdp; v.wrp = wrp; v.exp_rd0 = e0; v.exp_rd1 = e1;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one single-requester transaction and checks the whole handshake.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc = 0, rdc = 0, wrc = 0, g0 = 0, g1 = 0;
    logic seen = 1'b0;
    logic [23:0] ma = '0;
    req0 = !v.own; req1 = v.own;
    write0 = v.own ? !v.w : v.w;             write1 = v.own ? v.w : !v.w;
    address0 = v.own ? (v.addr ^ 24'h5) : v.addr; address1 = v.own ? v.addr : (v.addr ^ 24'h5);
    wdata0 = v.own ? ~v.wdata : v.wdata;     wdata1 = v.own ? v.wdata : ~v.wdata;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (mem_read) rdc++;
      if (mem_write) wrc++;
      if (mem_read || mem_write) ma = mem_address;
      if (gnt0) g0++;
      if (gnt1) g1++;
      if (done0 || done1) begin
        seen = 1'b1;
        check("done_sel", idx, {done1, done0}, v.own ? 2'b10 : 2'b01);
        check("error", idx, {error1, error0}, v.own ? {v.err, 1'b0} : {1'b0, v.err});
        check("rd0", idx, rd0, v.exp_rd0);
        check("rd1", idx, rd1, v.exp_rd1);
      end
    end
    check("done_seen", idx, seen, 1);
    check("latency", idx, cyc, 2);
    check("read_pulses", idx, rdc, v.rdp);
    check("write_pulses", idx, wrc, v.wrp);
    check("gnt_cycles", idx, {g1[7:0], g0[7:0]}, v.own ? 16'h0200 : 16'h0002);
    if (v.rdp + v.wrp > 0) check("mem_addr", idx, ma, v.addr);
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int ndone, overlap, cnt, cyc;
    logic first_owner;
    logic [3:0] order;
    int when [4];

    rst = 1'b1; mem_init = 1'b1;
    req0 = 0; req1 = 0; write0 = 0; write1 = 0;
    address0 = '0; address1 = '0; wdata0 = '0; wdata1 = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_ctrl", 0, {gnt0, gnt1, done0, done1, error0, error1, mem_write, mem_read}, 0);
    check("reset_maddr", 0, mem_address, 0);
    check("reset_mwdata", 0, mem_wdata, 0);
    check("reset_rd0", 0, rd0, 0);
    check("reset_rd1", 0, rd1, 0);
    mem_init = 1'b0; rst = 1'b0;
    @(negedge clk);

    vecs[0] = mk(0, 0, 24'd9,       24'h0,      0, 1, 0, 24'h123456, 24'h0);
    vecs[1] = mk(1, 1, 24'd30,      24'hABCDEF, 0, 0, 1, 24'h123456, 24'h0);
    vecs[2] = mk(1, 0, 24'd30,      24'h0,      0, 1, 0, 24'h123456, 24'hABCDEF);
    vecs[3] = mk(0, 0, 24'd126,     24'h0,      1, 0, 0, 24'h0,      24'hABCDEF);
    vecs[4] = mk(1, 1, 24'h000080,  24'h111111, 1, 0, 0, 24'h0,      24'h0);
    vecs[5] = mk(0, 0, 24'd125,     24'h0,      0, 1, 0, 24'h778899, 24'h0);
    vecs[6] = mk(0, 1, 24'd125,     24'h010203, 0, 0, 1, 24'h0,      24'h0);
    vecs[7] = mk(1, 0, 24'hFFFFFF,  24'h0,      1, 0, 0, 24'h0,      24'h0);
    vecs[8] = mk(1, 0, 24'd125,     24'h0,      0, 1, 0, 24'h0,      24'h010203);
    vecs[9] = mk(0, 0, 24'd127,     24'h0,      1, 0, 0, 24'h0,      24'h010203);
    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    check("mem30", 0, mem[30], 8'hAB);
    check("mem31", 0, mem[31], 8'hCD);
    check("mem32", 0, mem[32], 8'hEF);
    check("mem125", 0, mem[125], 8'h01);
    check("mem127", 0, mem[127], 8'h03);

    // Contention from reset: both held, grants alternate starting with requester 0.
    pulse_reset();
    req0 = 1; write0 = 0; address0 = 24'd9;
    req1 = 1; write1 = 0; address1 = 24'd30;
    ndone = 0; overlap = 0; cyc = 0; order = '0;
    while (ndone < 4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (gnt0 && gnt1) overlap++;
      if (done0 || done1) begin
        order[ndone] = done1;
        when[ndone] = cyc;
        ndone++;
        if (ndone == 4) begin req0 = 0; req1 = 0; end
      end
    end
    req0 = 0; req1 = 0;
    check("cont_count", 0, ndone, 4);
    check("cont_order", 0, order, 4'b1010);
    check("cont_overlap", 0, overlap, 0);
    for (int i = 1; i < 4; i++) check("cont_spacing", i, when[i] - when[i-1], 3);
    @(negedge clk);

    // Reset during the ACCESS cycle of a store.
    req1 = 1; write1 = 1; address1 = 24'd40; wdata1 = 24'h55AA33;
    @(negedge clk);
    check("abort_mw_before", 0, {gnt1, mem_write}, 2'b11);
    rst = 1'b1;
    #1;
    check("abort_mw_after", 0, {gnt1, mem_write, mem_read}, 0);
    req1 = 0;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done0 || done1) cnt++;
    end
    check("abort_no_done", 0, cnt, 0);
    check("abort_mem", 0, {mem[40], mem[41], mem[42]}, 24'h010203);
    req0 = 1; write0 = 0; address0 = 24'd9;
    req1 = 1; write1 = 0; address1 = 24'd30;
    first_owner = 1'b1; cnt = 0;
    for (int i = 0; i < 10 && cnt == 0; i++) begin
      @(negedge clk);
      if (done0 || done1) begin first_owner = done1; cnt++; end
    end
    req0 = 0; req1 = 0;
    check("abort_first_owner", 0, {cnt[0], first_owner}, 2'b10);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);

    // Requester 1 pulses for one cycle while requester 0 owns the memory.
    req0 = 1; write0 = 0; address0 = 24'd9;
    @(negedge clk);
    check("wd_owner", 0, {gnt1, gnt0}, 2'b01);
    req1 = 1; write1 = 0; address1 = 24'd30;
    @(negedge clk);
    check("wd_done0", 0, {done1, done0}, 2'b01);
    req1 = 0; req0 = 0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (gnt1 || done1) cnt++;
    end
    check("wd_no_gnt1", 0, cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter and access sequencer placed in front of the 24-bit byte-addressed data memory (128 bytes, big-endian 3-byte words, combinational read, write on rising edge). It shares the single memory port between requester 0 (CPU load/store stage) and requester 1 (debug/loader port) using round-robin arbitration. It registers address and data and range-checks every access. Each transaction gets a fixed-latency request/done handshake.

## Interface
- ADDR_WIDTH, 24, address width of requesters and memory port
- DATA_WIDTH, 24, word width (3 bytes)
- MEM_BYTES, 128, memory size in bytes; used for range check
- Clock  input  1  single clock, all state updates on rising edge
- Reset  input  1  asynchronous, active-high; forces IDLE
- Req0 / Req1  input  1  level request from requester 0 / 1
- Write0 / Write1  input  1  1 = store, 0 = load; valid while ReqN high
- Address0 / Address1  input  ADDR_WIDTH  byte address of word MSB
- WriteData0 / WriteData1  input  DATA_WIDTH  store data
- Gnt0 / Gnt1  output  1  requester owns the memory (ACCESS and RESP states)
- Done0 / Done1  output  1  one-cycle completion pulse
- Error0 / Error1  output  1  valid with DoneN; 1 = address out of range
- ReadData0 / ReadData1  output  DATA_WIDTH  load result, valid with DoneN
- MemAddress  output  ADDR_WIDTH  to memory Address
- MemWriteData  output  DATA_WIDTH  to memory WriteData
- MemWrite  output  1  to memory MemWrite
- MemRead  output  1  to memory MemRead
- MemReadData  input  DATA_WIDTH  from memory ReadData

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any ReqN is high at a rising edge, pick the owner. Latch Owner, Write, Address, WriteData. Compute RangeErr = (Address > MEM_BYTES-3), using a 24-bit unsigned compare with no wrap. Go to ACCESS. If no request, stay in IDLE.
- Arbitration: one requester only -> grant it. Both -> grant the one not granted last (LastGnt pointer). LastGnt updates at each grant.
- ACCESS (exactly 1 cycle):
  - MemAddress and MemWriteData come from the latches.
  - MemWrite = Write & ~RangeErr; MemRead = ~Write & ~RangeErr. Both are decoded combinationally from state.
  - At the closing edge: a load captures MemReadData into the owner's ReadData register (0 if RangeErr); a store leaves ReadData at 0. Go to RESP.
- RESP (exactly 1 cycle): DoneOwner=1, ErrorOwner=RangeErr. Next state is IDLE.
- Out-of-range access: no MemWrite/MemRead pulse. It still completes with Done and Error=1.
- Handshake: the requester holds ReqN and its operands stable from assertion until DoneN.
  - ReqN is sampled only in IDLE.
  - ReqN still high in the cycle after DoneN issues a new transaction.
  - Deasserting ReqN before grant withdraws the request.
- Non-owner outputs: Gnt, Done, Error = 0. ReadData holds its last value.

## Timing
- Reset values: state IDLE, LastGnt=1 (so requester 0 wins the first tie). All Gnt, Done, Error, MemWrite, MemRead = 0. MemAddress, MemWriteData, ReadData0/1 = 0.
- Latency: request sampled at edge E0 -> ACCESS during E0..E1 -> DoneN high during E1..E2 -> IDLE after E2.
  - Earliest next grant is at edge E3.
  - Throughput: 1 access per 3 cycles.
- Store commits at edge E1 (the memory's rising edge write). Load data is valid on ReadDataN from E1 onward.
- Reset asserted mid-transaction: state goes to IDLE immediately and MemWrite/MemRead drop asynchronously. A store not yet at E1 is lost. No Done is issued for the aborted transaction. LastGnt returns to 1.
- Simultaneous Req0 and Req1 with both held: the grants strictly alternate, 0,1,0,1...
- Address = MEM_BYTES-3 (125) is legal; 126 and 127 are errors, as is any address of 128 or above up to 24'hFFFFFF.

## Test plan
- Single load: memory preloaded with bytes 12,34,56 at addresses 9..11. Req0, Write0=0, Address0=9 -> Gnt0 high 2 cycles, MemRead one cycle with MemAddress=9, Done0 at cycle +2, ReadData0=24'h123456, Error0=0.
- Store then load: Req1 stores 24'hABCDEF at address 30 -> exactly one MemWrite pulse, Done1. A following load from 30 returns 24'hABCDEF, and bytes 30/31/32 = AB/CD/EF.
- Contention: Req0 and Req1 both held high for 4 transactions from reset -> grant order 0,1,0,1. Each Done is 3 cycles apart, and no overlap of Gnt0 and Gnt1.
- Range check: load at 126 and store at 24'h000080 -> Done with Error=1 and ReadData=0. MemWrite and MemRead never assert; memory contents are unchanged. Address 125 succeeds.
- Reset mid-store: assert Reset during ACCESS of a store to address 40 -> MemWrite drops at once, no Done, memory[40..42] unchanged. After release, Req1 and Req0 together -> requester 0 granted first.
- Withdrawn request: Req1 pulsed for one cycle while requester 0 owns the memory -> no Gnt1 or Done1 afterwards.
